// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Holds the FSM state type, the all-off pin patterns, the digit
// segment patterns (active-low {g,f,e,d,c,b,a}) and small anode helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // An anode pattern selects a digit only when exactly one bit is low.
    function automatic logic an_valid(input logic [3:0] a);
        return ((~a) != 4'b0000) && (((~a) & ((~a) - 4'd1)) == 4'b0000);
    endfunction

    // Position of the low bit; only meaningful for a valid pattern.
    function automatic logic [1:0] an_index(input logic [3:0] a);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment pattern decoder.
// Ports:
//   value : digit value 0..15
//   seg   : active-low segments {g,f,e,d,c,b,a}
// Build option SEG7_HEX_EN: when defined, 10..15 show A,b,C,d,E,F;
// otherwise they are blanked.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (value)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg = SEG_OFF;
`endif
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 7-segment pin driver placed after the digit scan stage.
// Registers the scan inputs, blanks all pins for BLANK_CYC cycles after any
// anode change (anti-ghosting), PWM-gates the anodes and drives the
// per-digit decimal point. All outputs are registered.
// Ports:
//   clk_in     : system clock
//   rst        : asynchronous active-high reset
//   num        : digit value for the selected anode
//   an_scan    : active-low anode select from the scan stage
//   brightness : PWM duty; anode lit while pwm_cnt <= brightness
//   dp_mask    : bit i lights the decimal point of digit i
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   an         : active-low anodes
// Build option SEG7_HEX_EN: enables hex glyphs for 10..15 (see seg7_decode).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned BLANK_CYC = 4,
    parameter int unsigned PWM_BITS  = 3
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [3:0]          num,
    input  logic [3:0]          an_scan,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [3:0]          dp_mask,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [3:0]          an
);

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYC - 1);

    state_e              state_q, state_d;
    logic [3:0]          an_q, an_prev_q, num_q;
    logic [7:0]          blank_cnt_q, blank_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [6:0]          seg_d, dec_seg;
    logic                dp_d;
    logic [3:0]          an_d;
    logic                an_ok, an_changed;

    seg7_decode u_decode (
        .value (num_q),
        .seg   (dec_seg)
    );

    assign an_ok      = an_valid(an_q);
    assign an_changed = (an_q != an_prev_q);
    assign pwm_cnt_d  = pwm_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (an_ok) begin
                    state_d     = StBlank;
                    blank_cnt_d = BLANK_LOAD;
                end
            end
            StBlank: begin
                if (!an_ok) begin
                    state_d = StIdle;
                end else if (an_changed) begin
                    blank_cnt_d = BLANK_LOAD;
                end else if (blank_cnt_q == 8'd0) begin
                    state_d = StShow;
                end else begin
                    blank_cnt_d = blank_cnt_q - 8'd1;
                end
            end
            StShow: begin
                if (!an_ok) begin
                    state_d = StIdle;
                end else if (an_changed) begin
                    state_d     = StBlank;
                    blank_cnt_d = BLANK_LOAD;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs follow the next state so a blank decision takes effect on the
    // very next edge; the anode gate uses the PWM value the pins will pair with.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = AN_OFF;
        if (state_d == StShow) begin
            seg_d = dec_seg;
            dp_d  = ~dp_mask[an_index(an_q)];
            an_d  = (pwm_cnt_d <= brightness) ? an_q : AN_OFF;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            an_q        <= AN_OFF;
            an_prev_q   <= AN_OFF;
            num_q       <= 4'd0;
            blank_cnt_q <= 8'd0;
            pwm_cnt_q   <= '0;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            an          <= AN_OFF;
        end else begin
            state_q     <= state_d;
            an_q        <= an_scan;
            an_prev_q   <= an_q;
            num_q       <= num;
            blank_cnt_q <= blank_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            seg         <= seg_d;
            dp          <= dp_d;
            an          <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios followed by
// random scan traffic, all compared every cycle against a reference model
// that reasons about the recent history of sampled anode patterns.
module tb_seg7_scan_driver;

    localparam int unsigned BLANK_CYC = 4;
    localparam int unsigned PWM_BITS  = 3;
    localparam int unsigned PWM_PER   = 1 << PWM_BITS;

    logic                clk_in = 1'b0;
    logic                rst = 1'b1;
    logic [3:0]          num = 4'd0;
    logic [3:0]          an_scan = 4'b1111;
    logic [PWM_BITS-1:0] brightness = '1;
    logic [3:0]          dp_mask = 4'd0;
    logic [6:0]          seg;
    logic                dp;
    logic [3:0]          an;

    seg7_scan_driver #(
        .BLANK_CYC (BLANK_CYC),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .num        (num),
        .an_scan    (an_scan),
        .brightness (brightness),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10,
`ifdef SEG7_HEX_EN
                7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        return tbl[v];
    endfunction

    // Reference model: a digit is shown only once the same valid anode has
    // been sampled BLANK_CYC+1 times in a row; lit while (cycle mod period)
    // is within the brightness level.
    logic [3:0]  hist [$];
    logic [3:0]  num_prev;
    int unsigned cyc;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < BLANK_CYC + 1; i++) hist.push_back(4'b1111);
        num_prev = 4'd0;
        cyc      = 0;
        exp_seg  = 7'h7F;
        exp_dp   = 1'b1;
        exp_an   = 4'b1111;
    endtask

    initial begin
        logic       stable;
        logic [3:0] cur;
        int         idx;
        model_reset();
        forever begin
            @(posedge clk_in or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                cyc++;
                cur    = hist[hist.size() - 1];
                stable = ($countones(~cur) == 1);
                foreach (hist[i]) if (hist[i] != cur) stable = 1'b0;
                if (stable) begin
                    idx = 0;
                    for (int b = 0; b < 4; b++) if (!cur[b]) idx = b;
                    exp_seg = ref_seg(num_prev);
                    exp_dp  = ~dp_mask[idx];
                    exp_an  = ((cyc % PWM_PER) <= brightness) ? cur : 4'b1111;
                end else begin
                    exp_seg = 7'h7F;
                    exp_dp  = 1'b1;
                    exp_an  = 4'b1111;
                end
                hist.push_back(an_scan);
                void'(hist.pop_front());
                num_prev = num;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (check_en) begin
                check_eq("seg", 32'(seg), 32'(exp_seg));
                check_eq("dp", 32'(dp), 32'(exp_dp));
                check_eq("an", 32'(an), 32'(exp_an));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Assert reset away from the clock edge and confirm pins drop at once.
    task automatic pulse_reset(input int hold);
        @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_dp", 32'(dp), 32'h1);
        check_eq("rst_an", 32'(an), 32'hF);
        repeat (hold) @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] n, input int len);
        an_scan = a;
        num     = n;
        cycles(len);
    endtask

    initial begin
        int         lit;
        logic [3:0] valid_an [4];
        valid_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        cycles(3);
        check_en = 1'b1;
        brightness = 3'd7;
        an_scan    = 4'b1110;
        num        = 4'd3;
        rst        = 1'b0;
        cycles(12);

        // Reset in the middle of a displayed digit.
        pulse_reset(2);
        cycles(12);

        drive(4'b1101, 4'd4, 10);
        drive(4'b1101, 4'd5, 5);

        drive(4'b1110, 4'd5, 10);
        drive(4'b1101, 4'd5, 2);
        drive(4'b1011, 4'd5, 10);

        brightness = 3'd2;
        cycles(3);
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (an != 4'b1111) lit++;
        end
        check_eq("duty_b2", 32'(lit), 32'd3);
        brightness = 3'd7;
        cycles(3);
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (an != 4'b1111) lit++;
        end
        check_eq("duty_b7", 32'(lit), 32'd8);
        brightness = 3'd0;
        cycles(17);
        brightness = 3'd7;

        drive(4'b1111, 4'd6, 8);
        drive(4'b1100, 4'd6, 8);
        drive(4'b1011, 4'd6, 10);

        dp_mask = 4'b1000;
        drive(4'b0111, 4'd12, 10);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) an_scan = 4'($urandom_range(0, 15));
                else an_scan = valid_an[$urandom_range(0, 3)];
            end
            if ($urandom_range(0, 2) == 0) num = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) brightness = PWM_BITS'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) pulse_reset($urandom_range(1, 2));
        end

        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
